// File: rtl/pad_share_arb.sv
// pad_share_arb: round-robin owner arbiter for one shared GPIO pad bank.
// Ports: clk_i, rst_n_i (sync, active-low); req*/gnt* handshake; out*/oen*/ren*
// requester drive; in* gated pad input; pad_i/oen/ren_o and pad_c_i pad cell pins;
// busy_o. Optional PAD_SHARE_ARB_SYNC_EN adds a 2-flop sync on pad_c_i.
module pad_share_arb #(
  parameter int PAD_NUM  = 8,
  parameter int TURN_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req0_i,
  input  logic               req1_i,
  output logic               gnt0_o,
  output logic               gnt1_o,
  input  logic [PAD_NUM-1:0] out0_i,
  input  logic [PAD_NUM-1:0] out1_i,
  input  logic [PAD_NUM-1:0] oen0_i,
  input  logic [PAD_NUM-1:0] oen1_i,
  input  logic [PAD_NUM-1:0] ren0_i,
  input  logic [PAD_NUM-1:0] ren1_i,
  output logic [PAD_NUM-1:0] in0_o,
  output logic [PAD_NUM-1:0] in1_o,
  output logic [PAD_NUM-1:0] pad_i_o,
  output logic [PAD_NUM-1:0] pad_oen_o,
  output logic [PAD_NUM-1:0] pad_ren_o,
  input  logic [PAD_NUM-1:0] pad_c_i,
  output logic               busy_o
);

  if (TURN_CYC < 1) begin : g_bad_turn
    $error("pad_share_arb: TURN_CYC must be >= 1");
  end
  if (PAD_NUM < 1 || PAD_NUM > 32) begin : g_bad_num
    $error("pad_share_arb: PAD_NUM must be 1..32");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] TURN = 2'd3;

  localparam int CW =
    (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  logic [1:0]         state;
  logic               rr;
  logic [CW-1:0]      cnt;
  logic [PAD_NUM-1:0] pad_in;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_i && req1_i)
            state <= rr ? OWN1 : OWN0;
          else if (req0_i)
            state <= OWN0;
          else if (req1_i)
            state <= OWN1;
        end
        OWN0: begin
          if (!req0_i) begin
            state <= TURN;
            cnt   <= CW'(TURN_CYC - 1);
            rr    <= 1'b1;
          end
        end
        OWN1: begin
          if (!req1_i) begin
            state <= TURN;
            cnt   <= CW'(TURN_CYC - 1);
            rr    <= 1'b0;
          end
        end
        TURN: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
      endcase
    end
  end

  assign gnt0_o = (state == OWN0);
  assign gnt1_o = (state == OWN1);
  assign busy_o = (state != IDLE);

`ifdef PAD_SHARE_ARB_SYNC_EN
  logic [PAD_NUM-1:0] sync1;
  logic [PAD_NUM-1:0] sync2;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_c_i;
      sync2 <= sync1;
    end
  end

  assign pad_in = sync2;
`else
  assign pad_in = pad_c_i;
`endif

  // Anything other than a live owner leaves the bank released.
  always_comb begin
    pad_i_o   = '0;
    pad_oen_o = '0;
    pad_ren_o = '1;
    unique case (1'b1)
      gnt0_o: begin
        pad_i_o   = out0_i;
        pad_oen_o = oen0_i;
        pad_ren_o = ren0_i;
      end
      gnt1_o: begin
        pad_i_o   = out1_i;
        pad_oen_o = oen1_i;
        pad_ren_o = ren1_i;
      end
      default: ;
    endcase
  end

  assign in0_o = gnt0_o ? pad_in : '0;
  assign in1_o = gnt1_o ? pad_in : '0;

endmodule

// File: tb/tb_pad_share_arb.sv
// tb_pad_share_arb: scoreboard bench for pad_share_arb with a
// directed prologue and a random phase against an ownership model.
module tb_pad_share_arb;

  localparam int TC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic       gnt0, gnt1, busy;
  logic [7:0] out0, out1, oen0, oen1;
  logic [7:0] ren0, ren1, in0, in1;
  logic [7:0] p_i, p_oen, p_ren, p_c;

  always #5 clk = ~clk;

  pad_share_arb #(.PAD_NUM(8), .TURN_CYC(TC)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req0), .req1_i(req1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .out0_i(out0), .out1_i(out1),
    .oen0_i(oen0), .oen1_i(oen1),
    .ren0_i(ren0), .ren1_i(ren1),
    .in0_o(in0), .in1_o(in1),
    .pad_i_o(p_i), .pad_oen_o(p_oen),
    .pad_ren_o(p_ren), .pad_c_i(p_c),
    .busy_o(busy)
  );

  typedef struct {
    logic       g0, g1, bz;
    logic [7:0] pi, po, pr, i0, i1;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: who owns the bank, how many release cycles remain,
  // who gets the tie next, and the pad-input history.
  int owner = -1;
  int turn_left = 0;
  int rr_m = 0;
  logic [7:0] h1 = '0, h2 = '0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0,
                       input logic r1,
                       input logic [7:0] o0, input logic [7:0] e0,
                       input logic [7:0] n0, input logic [7:0] o1,
                       input logic [7:0] e1, input logic [7:0] n1,
                       input logic [7:0] pc);
    exp_t e;
    logic [7:0] pin;
    @(negedge clk);
    rst_n = rst; req0 = r0; req1 = r1;
    out0 = o0; oen0 = e0; ren0 = n0;
    out1 = o1; oen1 = e1; ren1 = n1;
    p_c = pc;
    if (!rst) begin
      owner = -1; turn_left = 0; rr_m = 0;
      h1 = '0; h2 = '0;
    end else begin
      h2 = h1; h1 = pc;
      if (owner == 0 && !r0) begin
        owner = -1; turn_left = TC; rr_m = 1;
      end else if (owner == 1 && !r1) begin
        owner = -1; turn_left = TC; rr_m = 0;
      end else if (owner < 0 && turn_left > 0) begin
        turn_left--;
      end else if (owner < 0) begin
        if (r0 && r1) owner = rr_m;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
      end
    end
`ifdef PAD_SHARE_ARB_SYNC_EN
    pin = h2;
`else
    pin = pc;
`endif
    e.g0 = (owner == 0);
    e.g1 = (owner == 1);
    e.bz = (owner >= 0) || (turn_left > 0);
    e.pi = owner == 0 ? o0 : owner == 1 ? o1 : 8'h00;
    e.po = owner == 0 ? e0 : owner == 1 ? e1 : 8'h00;
    e.pr = owner == 0 ? n0 : owner == 1 ? n1 : 8'hFF;
    e.i0 = owner == 0 ? pin : 8'h00;
    e.i1 = owner == 1 ? pin : 8'h00;
    q.push_back(e);
  endtask

  task automatic simple(input logic rst, input logic r0,
                        input logic r1, input logic [7:0] pc);
    drive(rst, r0, r1, 8'hA5, 8'hFF, 8'h0F,
          8'h5A, 8'hF0, 8'h33, pc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt0", {7'b0, gnt0}, {7'b0, e.g0});
        chk("gnt1", {7'b0, gnt1}, {7'b0, e.g1});
        chk("busy", {7'b0, busy}, {7'b0, e.bz});
        chk("pad_i", p_i, e.pi);
        chk("pad_oen", p_oen, e.po);
        chk("pad_ren", p_ren, e.pr);
        chk("in0", in0, e.i0);
        chk("in1", in1, e.i1);
      end
    end
  end

  initial begin : stim
    logic r0, r1, rs;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    out0 = '0; out1 = '0; oen0 = '0; oen1 = '0;
    ren0 = '0; ren1 = '0; p_c = 8'h77;
    // Reset with busy-looking inputs.
    simple(1'b0, 1'b1, 1'b1, 8'h77);
    simple(1'b0, 1'b1, 1'b1, 8'h77);
    // Single requester, then release.
    repeat (3) simple(1'b1, 1'b1, 1'b0, 8'h3C);
    repeat (4) simple(1'b1, 1'b0, 1'b0, 8'h3C);
    // Contention, owner switch, round robin back to 0.
    repeat (4) simple(1'b1, 1'b1, 1'b1, 8'hC3);
    repeat (5) simple(1'b1, 1'b0, 1'b1, 8'hC3);
    simple(1'b1, 1'b1, 1'b0, 8'h11);
    repeat (5) simple(1'b1, 1'b1, 1'b1, 8'h22);
    // Reset while the bank is owned by 1.
    repeat (4) simple(1'b1, 1'b0, 1'b1, 8'h44);
    simple(1'b0, 1'b0, 1'b1, 8'h44);
    repeat (2) simple(1'b1, 1'b0, 1'b1, 8'h44);
    repeat (5) simple(1'b1, 1'b0, 1'b0, 8'h00);
    // Input path while owner 0.
    repeat (2) simple(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (4) simple(1'b1, 1'b1, 1'b0, 8'h3C);
    // Random phase.
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      rs = ($urandom_range(0, 60) != 0);
      drive(rs, r0, r1,
            8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
